// File: rtl/mmio_uart_tx_responder.sv
// Memory-mapped UART transmitter on the core's load/store port.
// Stores to TXDATA queue bytes in a FIFO that an 8N1 serialiser drains onto uart_tx.
module mmio_uart_tx_responder #(
    parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0100,
    parameter int          FIFO_DEPTH      = 16,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    input  logic [2:0]  bus_format,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    output logic [31:0] bus_read_data,
    output logic        bus_selected,
    output logic        uart_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic [15:0]   divisor, div_clamped;
    logic [15:0]   div_cnt, div_cnt_next, eff_div, eff_div_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic [7:0]    tx_byte, tx_byte_next;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overflow, full, empty, pop, load_frame;
    logic          sel, push_req, push_ok, drop, ovf_clear, div_lo_we, div_hi_we;
    logic [1:0]    reg_idx, offset;
    logic [3:0]    lane_mask;
    logic [7:0]    lane1_data;
    logic [31:0]   status_word, reg_word, shifted;
    logic          unused_upper;

    assign sel          = (bus_address[31:4] == BASE_ADDR[31:4]);
    assign bus_selected = sel;
    assign reg_idx      = bus_address[3:2];
    assign offset       = bus_address[1:0];
    assign unused_upper = ^bus_write_data[31:16];

    // Byte lanes touched by a store; misaligned or non-store formats touch none.
    always_comb begin
        lane_mask = 4'b0000;
        case (bus_format)
            3'b000:  lane_mask = 4'b0001 << offset;
            3'b001:  if (!offset[0]) lane_mask = 4'b0011 << offset;
            3'b010:  if (offset == 2'b00) lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
        if (!(sel && bus_write_enable)) lane_mask = 4'b0000;
    end

    assign lane1_data = offset[0] ? bus_write_data[7:0] : bus_write_data[15:8];
    assign push_req   = lane_mask[0] && (reg_idx == 2'd0);
    assign ovf_clear  = lane_mask[0] && (reg_idx == 2'd1) && bus_write_data[3];
    assign div_lo_we  = lane_mask[0] && (reg_idx == 2'd2);
    assign div_hi_we  = lane_mask[1] && (reg_idx == 2'd2);

    assign full        = (count == CW'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign push_ok     = push_req && (!full || pop);
    assign drop        = push_req && full && !pop;
    assign div_clamped = (divisor == 16'd0) ? 16'd1 : divisor;

    always_comb begin
        state_next   = state;
        div_cnt_next = div_cnt;
        eff_div_next = eff_div;
        bit_cnt_next = bit_cnt;
        tx_byte_next = tx_byte;
        load_frame   = 1'b0;
        pop          = 1'b0;
        uart_tx      = 1'b1;
        case (state)
            IDLE: load_frame = !empty;
            START: begin
                uart_tx = 1'b0;
                if (div_cnt == 16'd0) begin
                    state_next   = DATA;
                    div_cnt_next = eff_div - 16'd1;
                    bit_cnt_next = 3'd0;
                end else begin
                    div_cnt_next = div_cnt - 16'd1;
                end
            end
            DATA: begin
                uart_tx = tx_byte[bit_cnt];
                if (div_cnt == 16'd0) begin
                    div_cnt_next = eff_div - 16'd1;
                    if (bit_cnt == 3'd7) state_next = STOP;
                    else bit_cnt_next = bit_cnt + 3'd1;
                end else begin
                    div_cnt_next = div_cnt - 16'd1;
                end
            end
            STOP: begin
                if (div_cnt == 16'd0) begin
                    load_frame = !empty;
                    state_next = IDLE;
                end else begin
                    div_cnt_next = div_cnt - 16'd1;
                end
            end
        endcase
        // A new frame latches the divisor, so mid-frame DIVISOR writes wait for the next frame.
        if (load_frame) begin
            pop          = 1'b1;
            tx_byte_next = fifo_mem[rd_ptr];
            eff_div_next = div_clamped;
            div_cnt_next = div_clamped - 16'd1;
            state_next   = START;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            eff_div  <= 16'd1;
            bit_cnt  <= '0;
            tx_byte  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            divisor  <= DEFAULT_DIVISOR;
        end else begin
            state   <= state_next;
            div_cnt <= div_cnt_next;
            eff_div <= eff_div_next;
            bit_cnt <= bit_cnt_next;
            tx_byte <= tx_byte_next;
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop) count <= count + CW'(1);
            else if (pop && !push_ok) count <= count - CW'(1);
            if (drop) overflow <= 1'b1;
            else if (ovf_clear) overflow <= 1'b0;
            if (div_lo_we) divisor[7:0] <= bus_write_data[7:0];
            if (div_hi_we) divisor[15:8] <= lane1_data;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) fifo_mem[wr_ptr] <= bus_write_data[7:0];
    end

    assign status_word = {16'h0000, 8'(count), 4'h0, overflow, state != IDLE, empty, full};

    always_comb begin
        case (reg_idx)
            2'd1:    reg_word = status_word;
            2'd2:    reg_word = {16'h0000, divisor};
            default: reg_word = 32'h0000_0000;
        endcase
    end

    assign shifted = reg_word >> {offset, 3'b000};

    always_comb begin
        bus_read_data = 32'h0000_0000;
        if (sel && bus_read_enable) begin
            case (bus_format)
                3'b000:  bus_read_data = {{24{shifted[7]}}, shifted[7:0]};
                3'b001:  if (!offset[0]) bus_read_data = {{16{shifted[15]}}, shifted[15:0]};
                3'b010:  if (offset == 2'b00) bus_read_data = shifted;
                3'b100:  bus_read_data = {24'h000000, shifted[7:0]};
                3'b101:  if (!offset[0]) bus_read_data = {16'h0000, shifted[15:0]};
                default: bus_read_data = 32'h0000_0000;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx_responder.sv
// Bench for mmio_uart_tx_responder: byte-addressed register/FIFO/line model checked every cycle,
// directed literal checks, then randomized bus traffic.
module tb_mmio_uart_tx_responder;
    localparam logic [31:0] BASE  = 32'hFFFF_0100;
    localparam int          DEPTH = 16;
    localparam logic [2:0]  F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] bus_address, bus_write_data, bus_read_data;
    logic [2:0]  bus_format;
    logic        bus_read_enable, bus_write_enable, bus_selected, uart_tx;

    int checks   = 0;
    int failures = 0;

    mmio_uart_tx_responder #(
        .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIVISOR(16'd434)
    ) dut (
        .clock(clock), .reset(reset), .bus_address(bus_address),
        .bus_write_data(bus_write_data), .bus_format(bus_format),
        .bus_read_enable(bus_read_enable), .bus_write_enable(bus_write_enable),
        .bus_read_data(bus_read_data), .bus_selected(bus_selected), .uart_tx(uart_tx)
    );

    always #5 clock = ~clock;

    // Reference model: byte queue, sticky flag, divisor and the frame in flight as (byte, length, elapsed).
    logic [7:0]  mq[$];
    logic        m_ovf;
    logic [15:0] m_div;
    logic        m_active;
    logic [7:0]  m_byte;
    int          m_eff, m_elapsed;

    function automatic logic m_tx();
        int idx;
        if (!m_active) return 1'b1;
        idx = m_elapsed / m_eff;
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return m_byte[idx-1];
    endfunction

    function automatic logic [31:0] m_status();
        return {16'h0000, 8'(mq.size()), 4'h0, m_ovf, m_active, mq.size() == 0, mq.size() == DEPTH};
    endfunction

    function automatic logic [7:0] reg_byte(input logic [3:0] off, input logic [31:0] st);
        case (off)
            4'h4:    return st[7:0];
            4'h5:    return st[15:8];
            4'h8:    return m_div[7:0];
            4'h9:    return m_div[15:8];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] addr, input logic [2:0] fmt);
        int          size;
        logic [31:0] v, st;
        case (fmt)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        size = 0;
        endcase
        if (size == 0) return 32'h0;
        if ((int'(addr[1:0]) % size) != 0) return 32'h0;
        st = m_status();
        v  = 32'h0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = reg_byte(addr[3:0] + 4'(i), st);
        if (fmt == 3'b000) v = {{24{v[7]}}, v[7:0]};
        if (fmt == 3'b001) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    always @(posedge clock or negedge reset) begin : model_update
        int         sz;
        logic [3:0] off;
        logic [7:0] b, push_b;
        logic       push_req, clr, pop_now, was_full;
        if (!reset) begin
            mq.delete();
            m_ovf     = 1'b0;
            m_div     = 16'd434;
            m_active  = 1'b0;
            m_byte    = 8'h00;
            m_eff     = 1;
            m_elapsed = 0;
        end else begin
            push_req = 1'b0;
            push_b   = 8'h00;
            clr      = 1'b0;
            pop_now  = 1'b0;
            case (bus_format)
                3'b000:  sz = 1;
                3'b001:  sz = 2;
                3'b010:  sz = 4;
                default: sz = 0;
            endcase
            if (bus_write_enable && bus_address[31:4] == BASE[31:4] && sz != 0 &&
                (int'(bus_address[1:0]) % sz) == 0) begin
                for (int i = 0; i < sz; i++) begin
                    off = bus_address[3:0] + 4'(i);
                    b   = bus_write_data[8*i +: 8];
                    if (off == 4'h0) begin push_req = 1'b1; push_b = b; end
                    if (off == 4'h4 && b[3]) clr = 1'b1;
                end
            end
            was_full = (mq.size() == DEPTH);
            if (m_active && m_elapsed + 1 < 10 * m_eff) begin
                m_elapsed++;
            end else if (mq.size() > 0) begin
                m_byte    = mq.pop_front();
                m_eff     = (m_div == 16'd0) ? 1 : int'(m_div);
                m_elapsed = 0;
                m_active  = 1'b1;
                pop_now   = 1'b1;
            end else begin
                m_active = 1'b0;
            end
            if (clr) m_ovf = 1'b0;
            if (push_req) begin
                if (!was_full || pop_now) mq.push_back(push_b);
                else m_ovf = 1'b1;
            end
            if (sz != 0 && bus_write_enable && bus_address[31:4] == BASE[31:4] &&
                (int'(bus_address[1:0]) % sz) == 0) begin
                for (int i = 0; i < sz; i++) begin
                    off = bus_address[3:0] + 4'(i);
                    if (off == 4'h8) m_div[7:0]  = bus_write_data[8*i +: 8];
                    if (off == 4'h9) m_div[15:8] = bus_write_data[8*i +: 8];
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clock) begin : compare
        logic        exp_sel;
        logic [31:0] exp_rd;
        exp_sel = (bus_address[31:4] == BASE[31:4]);
        exp_rd  = (bus_read_enable && exp_sel) ? m_read(bus_address, bus_format) : 32'h0;
        check_output("model_uart_tx", {31'b0, uart_tx}, {31'b0, m_tx()});
        check_output("model_bus_selected", {31'b0, bus_selected}, {31'b0, exp_sel});
        check_output("model_bus_read_data", bus_read_data, exp_rd);
    end

    task automatic apply_stimulus(input logic we, input logic re, input logic [31:0] addr,
                                  input logic [31:0] data, input logic [2:0] fmt);
        @(posedge clock);
        #2;
        bus_write_enable = we;
        bus_read_enable  = re;
        bus_address      = addr;
        bus_write_data   = data;
        bus_format       = fmt;
    endtask

    task automatic bus_idle();
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] fmt);
        apply_stimulus(1'b1, 1'b0, addr, data, fmt);
    endtask

    task automatic wait_cycles(input int n);
        bus_idle();
        repeat (n - 1) @(posedge clock);
    endtask

    task automatic read_check(input string name, input logic [31:0] addr, input logic [2:0] fmt,
                              input logic [31:0] expected);
        apply_stimulus(1'b0, 1'b1, addr, 32'h0, fmt);
        @(negedge clock);
        check_output(name, bus_read_data, expected);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [9:0]  frame;
        logic [19:0] seen;
        int          r, rg, off;
        logic [31:0] addr, data;
        logic [2:0]  fmt;

        reset = 1'b1;
        bus_write_enable = 1'b0;
        bus_read_enable  = 1'b0;
        bus_address      = 32'h0;
        bus_write_data   = 32'h0;
        bus_format       = 3'b000;
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;

        read_check("status_reset", BASE + 32'h4, F_W, 32'h0000_0002);
        check_output("tx_idle_reset", {31'b0, uart_tx}, 32'h1);
        read_check("divisor_reset", BASE + 32'h8, F_W, 32'd434);

        // One 0x55 frame at 4 clocks per bit.
        store(BASE + 32'h8, 32'd4, F_W);
        store(BASE, 32'h55, F_B);
        bus_idle();
        @(negedge clock);
        check_output("tx_before_start", {31'b0, uart_tx}, 32'h1);
        @(negedge clock);
        check_output("start_bit_first_cycle", {31'b0, uart_tx}, 32'h0);
        @(negedge clock);
        frame = {1'b1, 8'h55, 1'b0};
        for (int k = 1; k < 10; k++) begin
            repeat (4) @(negedge clock);
            check_output($sformatf("frame55_bit%0d", k), {31'b0, uart_tx}, {31'b0, frame[k]});
        end
        read_check("status_busy_stop", BASE + 32'h4, F_W, 32'h0000_0006);
        read_check("status_busy_last", BASE + 32'h4, F_W, 32'h0000_0006);
        read_check("status_idle_after", BASE + 32'h4, F_W, 32'h0000_0002);

        // Lane writes and extended loads on DIVISOR.
        store(BASE + 32'h8, 32'h0000_ABCD, F_H);
        read_check("lb_divisor", BASE + 32'h8, F_B, 32'hFFFF_FFCD);
        read_check("lbu_divisor_hi", BASE + 32'h9, F_BU, 32'h0000_00AB);
        store(BASE + 32'h9, 32'h0000_0012, F_B);
        read_check("divisor_lane1", BASE + 32'h8, F_W, 32'h0000_12CD);
        read_check("lhu_divisor", BASE + 32'h8, F_HU, 32'h0000_12CD);

        // Back-to-back frames at divisor 1, then divisor 0 treated as 1.
        store(BASE + 32'h8, 32'd1, F_W);
        store(BASE, 32'hC3, F_B);
        store(BASE, 32'h5A, F_B);
        bus_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            seen[i] = uart_tx;
        end
        check_output("b2b_frames", {12'b0, seen}, {12'b0, 20'b1010110100_1110000110});
        read_check("status_after_b2b", BASE + 32'h4, F_W, 32'h0000_0002);
        store(BASE + 32'h8, 32'd0, F_W);
        store(BASE, 32'h0F, F_B);
        bus_idle();
        @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            seen[i] = uart_tx;
        end
        check_output("div0_frame", {22'b0, seen[9:0]}, {22'b0, 10'b1000011110});

        // Overflow while a long frame is busy, then reset mid-DATA.
        store(BASE + 32'h8, 32'd200, F_W);
        store(BASE, 32'hA0, F_B);
        wait_cycles(3);
        for (int i = 0; i < 17; i++) store(BASE, 32'(i), F_B);
        read_check("status_overflow", BASE + 32'h4, F_W, 32'h0000_100D);
        store(BASE + 32'h4, 32'h8, F_W);
        read_check("status_ovf_cleared", BASE + 32'h4, F_W, 32'h0000_1005);
        wait_cycles(250);
        @(negedge clock);
        check_output("tx_data_bit0_a0", {31'b0, uart_tx}, 32'h0);
        @(posedge clock);
        #2;
        bus_read_enable = 1'b1;
        bus_address     = BASE + 32'h4;
        bus_format      = F_W;
        reset           = 1'b0;
        @(negedge clock);
        check_output("tx_reset_abort", {31'b0, uart_tx}, 32'h1);
        check_output("status_in_reset", bus_read_data, 32'h0000_0002);
        @(posedge clock);
        #2 reset = 1'b1;
        store(BASE + 32'h1, 32'hFFFF_FFFF, F_W);
        store(32'h0000_0100, 32'h77, F_B);
        read_check("status_after_ignored", BASE + 32'h4, F_W, 32'h0000_0002);
        read_check("divisor_after_reset", BASE + 32'h8, F_W, 32'd434);

        // Randomized traffic against the model.
        store(BASE + 32'h8, 32'd2, F_W);
        for (int it = 0; it < 3000; it++) begin
            if (it == 1500) begin
                bus_idle();
                #1 reset = 1'b0;
                @(posedge clock);
                #2 reset = 1'b1;
                store(BASE + 32'h8, 32'd1, F_W);
            end
            r    = $urandom_range(0, 9);
            rg   = $urandom_range(0, 3);
            off  = $urandom_range(0, 3);
            addr = BASE + 32'(rg * 4 + off);
            if ($urandom_range(0, 7) == 0) addr = addr ^ 32'h0010_0000;
            if (r <= 2) begin
                bus_idle();
            end else if (r <= 5) begin
                fmt  = 3'($urandom_range(0, 2));
                data = $urandom;
                if (rg == 2) data = (off == 0) ? 32'($urandom_range(0, 3)) : 32'h0;
                store(addr, data, fmt);
            end else begin
                fmt = 3'($urandom_range(0, 7));
                apply_stimulus(1'b0, 1'b1, addr, 32'h0, fmt);
            end
        end
        bus_idle();
        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
